sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Sequences MEM-stage data accesses (mem_read / mem_write decoded by the control unit) onto a 16-bit, multi-cycle asynchronous SRAM.
- Each 32-bit word is split into two 16-bit halves, low half first. Each half is held for a programmable number of wait cycles.
- Drives ready low while an access is in flight; the hazard/pipeline logic uses it as freeze.
- Sits between the MEM stage and the board SRAM pins.

Parameters:
- WAIT_CYCLES, 5: cycles each 16-bit phase is held on the SRAM bus (legal range 1..15).
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request from MEM stage.
- mem_write  in  1  store request from MEM stage.
- address  in  32  byte address from ALU.
- write_data  in  32  store data.
- read_data  out  32  load result, valid when ready=1 after a read.
- ready  out  1  access complete / no access pending; 0 = freeze pipeline.
- sram_addr  out  SRAM_ADDR_W  SRAM half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data returned from SRAM.
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the pad.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, truncated to SRAM_ADDR_W-1 bits.
  - LO phase uses sram_addr = {word,1'b0}; HI phase uses {word,1'b1}.
  - address[1:0] is ignored.
- States:
  - IDLE: if mem_write or mem_read, latch address, write_data and op, then go to LO. A write wins if both are asserted (illegal combination, no error flagged).
  - LO: hold the low-half phase for WAIT_CYCLES cycles (counter 0..WAIT_CYCLES-1), then go to HI with counter=0.
  - HI: same as LO for the high half, then go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- ready (combinational):
  - 1 in IDLE when no request is asserted, and 1 in DONE.
  - 0 in IDLE when a request is asserted, and 0 in LO and HI.
- Latency: request to ready=1 is 2*WAIT_CYCLES+1 stall cycles; ready is high in the DONE cycle. Back-to-back requests restart from IDLE, so there is one IDLE cycle with ready=0 between accesses.
- Writes:
  - During LO/HI: sram_dq_oe=1, sram_dq_out = latched write_data[15:0] / [31:16].
  - sram_we_n=0 for counter 0..WAIT_CYCLES-2 and 1 on the last cycle of each phase (data hold before the next phase).
  - With WAIT_CYCLES=1, sram_we_n stays 0 for that single cycle.
- Reads:
  - sram_dq_oe=0, sram_we_n=1.
  - On the last cycle of LO, capture sram_dq_in into read_data[15:0]; on the last cycle of HI, into read_data[31:16].
  - read_data holds its value until the next read overwrites it.
- Request inputs are sampled only in IDLE. Deassertion mid-access is ignored and the access completes.
- An rst_n assertion mid-access aborts immediately to reset values; a partial write may remain in the SRAM.

Optional Feature:
- Macro: SRAM_STALL_CNT_EN.
- Defined:
  - Adds output port stall_count (32 bits), reset to 0.
  - Increments on every clock where ready=0; saturates at 0xFFFFFFFF.
  - Adds input stall_clr (1 bit), which synchronously clears the count to 0; clear wins over increment.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- Reset then idle with no request: ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0 for 20 cycles.
- Store: mem_write=1, address=1024, write_data=0xDEADBEEF, WAIT_CYCLES=5 -> SRAM model holds word 0=0xBEEF and word 1=0xDEAD; ready=0 for exactly 11 cycles, then 1 for one cycle.
- Load: mem_read=1, address=1032 after SRAM words 4/5 preloaded with 0x5678/0x1234 -> read_data=0x12345678 when ready rises; sram_we_n stays 1 throughout.
- Back-to-back: a store to 1028 followed immediately by a load from 1028 -> the load returns the stored value; the two accesses are separated by one IDLE cycle with ready=0.
- Reset mid-access: assert rst_n=0 during the HI phase of a store -> all outputs return to reset values in the same cycle (asynchronous), and after release state=IDLE with ready=1.
- With SRAM_STALL_CNT_EN defined: one store plus one load at WAIT_CYCLES=5 -> stall_count=22; pulse stall_clr -> 0 on the next cycle.

Source files
------------

// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two half-word phases (low half first). Each phase is held for WAIT_CYCLES
// clocks. The ready output doubles as the pipeline freeze (0 = stall).
//
// Optional build macro: SRAM_STALL_CNT_EN
//   When defined, adds stall_clr (in) and stall_count (out). stall_count is a
//   saturating count of the clocks on which ready was low.
module sram_mem_controller #(
   parameter int WAIT_CYCLES = 5,
   parameter int BASE_ADDR   = 1024,
   parameter int SRAM_ADDR_W = 18
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
`ifdef SRAM_STALL_CNT_EN
   ,
   input  logic                   stall_clr,
   output logic [31:0]            stall_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   // Word index width: one SRAM address bit selects the half-word.
   localparam int          WORD_W   = SRAM_ADDR_W - 1;
   localparam logic [31:0] BASE     = 32'(BASE_ADDR);
   localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
   // With a single-cycle phase there is no room for a hold cycle, so the
   // write strobe stays low for the whole phase.
   localparam bit          ONE_CYCLE_PHASE = (WAIT_CYCLES == 1);

   state_t                 state_q,       state_d;
   logic [3:0]             cnt_q,         cnt_d;
   logic                   is_write_q,    is_write_d;
   logic [WORD_W-1:0]      word_q,        word_d;
   logic [31:0]            wdata_q,       wdata_d;
   logic [31:0]            read_data_q,   read_data_d;
   logic [SRAM_ADDR_W-1:0] sram_addr_q,   sram_addr_d;
   logic [15:0]            sram_dq_out_q, sram_dq_out_d;
   logic                   sram_dq_oe_q,  sram_dq_oe_d;
   logic                   sram_we_n_q,   sram_we_n_d;

   logic                   req;
   logic [31:0]            offset;
   logic [WORD_W-1:0]      req_word;
   logic                   unused_offset_bits;

   assign req      = mem_read | mem_write;
   assign offset   = address - BASE;
   assign req_word = offset[WORD_W+1:2];
   // Byte lane bits and bits beyond the SRAM reach are intentionally dropped.
   assign unused_offset_bits = ^{offset[31:WORD_W+2], offset[1:0]};

   // ready is combinational so the pipeline freezes in the request cycle.
   assign ready = ((state_q == IDLE) && !req) || (state_q == DONE);

   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = sram_dq_out_q;
   assign sram_dq_oe  = sram_dq_oe_q;
   assign sram_we_n   = sram_we_n_q;

   // Next-state, capture and registered SRAM pin values.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      is_write_d    = is_write_q;
      word_d        = word_q;
      wdata_d       = wdata_q;
      read_data_d   = read_data_q;
      sram_addr_d   = sram_addr_q;
      sram_dq_out_d = sram_dq_out_q;
      sram_dq_oe_d  = 1'b0;
      sram_we_n_d   = 1'b1;

      case (state_q)
         IDLE: begin
            if (req) begin
               // A store wins when both strobes are asserted.
               state_d    = LO;
               cnt_d      = 4'd0;
               is_write_d = mem_write;
               word_d     = req_word;
               wdata_d    = write_data;
            end
         end
         LO: begin
            if (cnt_q == LAST_CNT) begin
               if (!is_write_q) begin
                  read_data_d[15:0] = sram_dq_in;
               end
               state_d = HI;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         HI: begin
            if (cnt_q == LAST_CNT) begin
               if (!is_write_q) begin
                  read_data_d[31:16] = sram_dq_in;
               end
               state_d = DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Pin values are derived from the state being entered so that they are
      // valid for the whole of each phase cycle straight out of a flop.
      if ((state_d == LO) || (state_d == HI)) begin
         sram_addr_d  = {word_d, (state_d == HI)};
         sram_dq_oe_d = is_write_d;
         if (is_write_d) begin
            sram_dq_out_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
            // Strobe low except on the final cycle, which holds data stable.
            sram_we_n_d   = !((cnt_d != LAST_CNT) || ONE_CYCLE_PHASE);
         end
      end
   end

   // Controller state and registered outputs; reset aborts any access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         is_write_q    <= 1'b0;
         word_q        <= '0;
         wdata_q       <= 32'd0;
         read_data_q   <= 32'd0;
         sram_addr_q   <= '0;
         sram_dq_out_q <= 16'd0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         is_write_q    <= is_write_d;
         word_q        <= word_d;
         wdata_q       <= wdata_d;
         read_data_q   <= read_data_d;
         sram_addr_q   <= sram_addr_d;
         sram_dq_out_q <= sram_dq_out_d;
         sram_dq_oe_q  <= sram_dq_oe_d;
         sram_we_n_q   <= sram_we_n_d;
      end
   end

`ifdef SRAM_STALL_CNT_EN
   logic [31:0] stall_count_q, stall_count_d;

   assign stall_count = stall_count_q;

   // Saturating stall counter; a clear request takes priority.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall_clr) begin
         stall_count_d = 32'd0;
      end else if (!ready && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= 32'd0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed testbench for sram_mem_controller with a behavioural 16-bit SRAM.
// Build with SRAM_STALL_CNT_EN defined to also exercise the stall counter.
module tb_sram_mem_controller;

   localparam int W = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;
`ifdef SRAM_STALL_CNT_EN
   logic        stall_clr = 1'b0;
   logic [31:0] stall_count;
`endif

   int vectors = 0;
   int miscompares = 0;

   // SRAM model plus a preload port used by the bench.
   logic [15:0] mem [0:63];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_addr = 6'd0;
   logic [15:0] pre_data = 16'd0;

   always #5 clk = ~clk;

   assign sram_dq_in = mem[sram_addr[5:0]];

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (!sram_we_n) begin
         mem[sram_addr[5:0]] <= sram_dq_out;
      end
   end

   sram_mem_controller #(
      .WAIT_CYCLES(W),
      .BASE_ADDR(1024),
      .SRAM_ADDR_W(18)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .address(address),
      .write_data(write_data),
      .read_data(read_data),
      .ready(ready),
      .sram_addr(sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe),
      .sram_we_n(sram_we_n)
`ifdef SRAM_STALL_CNT_EN
      ,
      .stall_clr(stall_clr),
      .stall_count(stall_count)
`endif
   );

   task automatic preload(input logic [5:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   // One access: checks the request cycle, every phase cycle and DONE.
   task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] wd, input int exp_word,
                            input logic [31:0] exp_rd, input string tag);
      logic [17:0] exp_addr;
      logic        exp_we_n;
      logic [15:0] exp_dq;
      int          ph;
      int          c;
      @(posedge clk); #1;
      mem_write = wr; mem_read = rd; address = addr; write_data = wd;
      @(negedge clk);
      vectors++;
      if (ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_req_ready got %b expected 0", tag, ready);
      end
      @(posedge clk); #1;
      mem_write = 1'b0; mem_read = 1'b0; address = 32'hFFFF_FFFF; write_data = 32'h0;
      for (int k = 0; k < 2 * W; k++) begin
         ph = k / W;
         c  = k % W;
         exp_addr = 18'(exp_word * 2 + ph);
         exp_we_n = wr ? ((c == W - 1) && (W > 1)) : 1'b1;
         exp_dq   = (ph == 1) ? wd[31:16] : wd[15:0];
         @(negedge clk);
         vectors++;
         if (ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ready cyc%0d got %b expected 0", tag, k, ready);
         end
         vectors++;
         if (sram_addr !== exp_addr) begin
            miscompares++;
            $display("FAIL %s_sram_addr cyc%0d got %h expected %h", tag, k, sram_addr, exp_addr);
         end
         vectors++;
         if (sram_we_n !== exp_we_n) begin
            miscompares++;
            $display("FAIL %s_we_n cyc%0d got %b expected %b", tag, k, sram_we_n, exp_we_n);
         end
         vectors++;
         if (sram_dq_oe !== wr) begin
            miscompares++;
            $display("FAIL %s_dq_oe cyc%0d got %b expected %b", tag, k, sram_dq_oe, wr);
         end
         if (wr) begin
            vectors++;
            if (sram_dq_out !== exp_dq) begin
               miscompares++;
               $display("FAIL %s_dq_out cyc%0d got %h expected %h", tag, k, sram_dq_out, exp_dq);
            end
         end
      end
      @(negedge clk);
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_done_ready got %b expected 1", tag, ready);
      end
      vectors++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_done_pins got we_n=%b oe=%b expected we_n=1 oe=0", tag, sram_we_n, sram_dq_oe);
      end
      if (rd && !wr) begin
         vectors++;
         if (read_data !== exp_rd) begin
            miscompares++;
            $display("FAIL %s_read_data got %h expected %h", tag, read_data, exp_rd);
         end
      end
      $display("access %s addr=%h wdata=%h read_data=%h", tag, addr, wd, read_data);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #10;
      vectors++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 ||
          sram_dq_out !== 16'd0 || read_data !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_values got we_n=%b oe=%b addr=%h dq=%h rd=%h expected 1 0 0 0 0",
                  sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vectors++;
         if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'd0) begin
            miscompares++;
            $display("FAIL idle_cyc%0d got ready=%b we_n=%b oe=%b rd=%h expected 1 1 0 0",
                     i, ready, sram_we_n, sram_dq_oe, read_data);
         end
      end
      $display("reset and idle checked");
   endtask

   task automatic test_store();
      do_access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 0, 32'h0, "store");
      vectors++;
      if (mem[0] !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL store_word0 got %h expected beef", mem[0]);
      end
      vectors++;
      if (mem[1] !== 16'hDEAD) begin
         miscompares++;
         $display("FAIL store_word1 got %h expected dead", mem[1]);
      end
      @(negedge clk);
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL store_after_ready got %b expected 1", ready);
      end
   endtask

   task automatic test_load();
      preload(6'd4, 16'h5678);
      preload(6'd5, 16'h1234);
      do_access(1'b0, 1'b1, 32'd1032, 32'h0, 2, 32'h1234_5678, "load");
      repeat (3) @(negedge clk);
      vectors++;
      if (read_data !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL load_hold got %h expected 12345678", read_data);
      end
   endtask

   task automatic test_back_to_back();
      do_access(1'b1, 1'b0, 32'd1028, 32'hA5A5_3C3C, 1, 32'h0, "b2b_store");
      do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1, 32'hA5A5_3C3C, "b2b_load");
   endtask

   task automatic test_write_priority();
      // Both strobes set and low address bits nonzero: 1047 -> word 5.
      do_access(1'b1, 1'b1, 32'd1047, 32'hCAFE_F00D, 5, 32'h0, "both");
      vectors++;
      if (mem[10] !== 16'hF00D || mem[11] !== 16'hCAFE) begin
         miscompares++;
         $display("FAIL both_mem got %h_%h expected cafe_f00d", mem[11], mem[10]);
      end
      vectors++;
      if (read_data !== 32'hA5A5_3C3C) begin
         miscompares++;
         $display("FAIL both_read_data_hold got %h expected a5a53c3c", read_data);
      end
   endtask

   task automatic test_reset_mid_access();
      @(posedge clk); #1;
      mem_write = 1'b1; address = 32'd1036; write_data = 32'h1111_2222;
      @(posedge clk); #1;
      mem_write = 1'b0;
      repeat (W + 2) @(negedge clk);
      vectors++;
      if (sram_addr !== 18'd7 || sram_we_n !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_in_hi got addr=%h we_n=%b expected 7 0", sram_addr, sram_we_n);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'd0 ||
          sram_dq_out !== 16'd0 || read_data !== 32'd0 || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_values got we_n=%b oe=%b addr=%h dq=%h rd=%h ready=%b expected 1 0 0 0 0 1",
                  sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data, ready);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_release got ready=%b we_n=%b expected 1 1", ready, sram_we_n);
      end
      vectors++;
      if (mem[6] !== 16'h2222) begin
         miscompares++;
         $display("FAIL midrst_lo_half got %h expected 2222", mem[6]);
      end
      $display("reset during store checked");
   endtask

`ifdef SRAM_STALL_CNT_EN
   task automatic test_stall_count();
      @(posedge clk); #1 stall_clr = 1'b1;
      @(posedge clk); #1 stall_clr = 1'b0;
      @(negedge clk);
      vectors++;
      if (stall_count !== 32'd0) begin
         miscompares++;
         $display("FAIL stall_start got %0d expected 0", stall_count);
      end
      do_access(1'b1, 1'b0, 32'd1052, 32'h0BAD_F00D, 7, 32'h0, "stall_store");
      @(negedge clk);
      do_access(1'b0, 1'b1, 32'd1052, 32'h0, 7, 32'h0BAD_F00D, "stall_load");
      @(negedge clk);
      vectors++;
      if (stall_count !== 32'd22) begin
         miscompares++;
         $display("FAIL stall_count got %0d expected 22", stall_count);
      end
      @(posedge clk); #1 stall_clr = 1'b1;
      @(negedge clk);
      vectors++;
      if (stall_count !== 32'd0) begin
         miscompares++;
         $display("FAIL stall_clr got %0d expected 0", stall_count);
      end
      @(posedge clk); #1 stall_clr = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_store();
      test_load();
      test_back_to_back();
      test_write_priority();
      test_reset_mid_access();
`ifdef SRAM_STALL_CNT_EN
      test_stall_count();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
